lm_encoder: RTL and testbench

LED-manager encoder: the write side of the LED-manager FIFO. It collects display requests from up to N_SRC producer modules and from a single error channel. It arbitrates between them, with errors first and then round-robin, and pushes one LED pattern word at a time into the FIFO. A programmable hold gap between consecutive writes paces the LED updates and guarantees that `fifo_full` is re-sampled after every push.

---
 rtl/lm_encoder.sv | 161 ++++++++++++++++
 tb/tb_lm_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_encoder.sv
// LED-manager encoder: collects LED pattern requests from N_SRC producers and
// an error channel, arbitrates (error first, then round-robin) and paces FIFO pushes.

module lm_src_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             grant,
    output logic             pend,
    output logic [WIDTH-1:0] word
);
    // grant only fires while pend is set, so it can never collide with an accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            word <= '0;
        end else if (grant) begin
            pend <= 1'b0;
        end else if (valid && !pend) begin
            pend <= 1'b1;
            word <= data;
        end
    end
endmodule

module lm_encoder #(
    parameter int WIDTH       = 8,
    parameter int N_SRC       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    output logic [N_SRC-1:0]       src_ready,
    input  logic                   err_valid,
    input  logic [WIDTH-1:0]       err_code,
    input  logic                   fifo_full,
    output logic                   wr_en,
    output logic [WIDTH-1:0]       wr_data,
    output logic                   err_overrun,
    output logic                   busy
);
    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic [PTR_W-1:0]              rr_ptr, rr_nxt;
    logic [N_SRC-1:0]              pend, grant;
    logic [N_SRC-1:0][WIDTH-1:0]   word;
    logic                          err_pend, err_grant;
    logic [WIDTH-1:0]              err_buf;
    logic                          wr_en_nxt;
    logic [WIDTH-1:0]              wr_data_nxt;
    logic                          rr_hit;
    logic [PTR_W-1:0]              rr_sel;
    logic [PTR_W:0]                rr_sum;

    for (genvar i = 0; i < N_SRC; i++) begin : g_slot
        lm_src_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .valid (src_valid[i]),
            .data  (src_data[i*WIDTH +: WIDTH]),
            .grant (grant[i]),
            .pend  (pend[i]),
            .word  (word[i])
        );
    end

    assign src_ready = ~pend;
    assign busy      = (state != IDLE) | (|pend) | err_pend;

    // Search from rr_ptr upward with wrap; walking j downward lets the closest hit win.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = rr_ptr;
        rr_sum = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            rr_sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
            if (rr_sum >= (PTR_W+1)'(N_SRC))
                rr_sum = rr_sum - (PTR_W+1)'(N_SRC);
            if (pend[rr_sum[PTR_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_sel = rr_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rr_nxt      = rr_ptr;
        wr_en_nxt   = 1'b0;
        wr_data_nxt = wr_data;
        grant       = '0;
        err_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_full && (err_pend || rr_hit)) begin
                    state_nxt = WRITE;
                    wr_en_nxt = 1'b1;
                    if (err_pend) begin
                        err_grant   = 1'b1;
                        wr_data_nxt = err_buf;
                    end else begin
                        grant[rr_sel] = 1'b1;
                        wr_data_nxt   = word[rr_sel];
                        rr_nxt        = (rr_sel == PTR_W'(N_SRC - 1)) ? '0 : rr_sel + 1'b1;
                    end
                end
            end
            WRITE: begin
                state_nxt = HOLD;
                cnt_nxt   = CNT_W'(HOLD_CYCLES);
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rr_ptr  <= rr_nxt;
            wr_en   <= wr_en_nxt;
            wr_data <= wr_data_nxt;
        end
    end

    // A new error on the edge that grants the old one is a hand-off, not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pend    <= 1'b0;
            err_buf     <= '0;
            err_overrun <= 1'b0;
        end else if (err_valid) begin
            err_pend <= 1'b1;
            err_buf  <= err_code;
            if (err_pend && !err_grant) err_overrun <= 1'b1;
        end else if (err_grant) begin
            err_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lm_encoder.sv
// Bench for lm_encoder: directed scenarios plus random traffic, all cycles
// compared against a transaction-level model of the arbiter.

module tb_lm_encoder;
    localparam int W = 8;
    localparam int N = 4;
    localparam int H = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   src_valid = '0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_ready;
    logic           err_valid = 1'b0;
    logic [W-1:0]   err_code = '0;
    logic           fifo_full = 1'b0;
    logic           wr_en;
    logic [W-1:0]   wr_data;
    logic           err_overrun;
    logic           busy;

    lm_encoder #(.WIDTH(W), .N_SRC(N), .HOLD_CYCLES(H), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .fifo_full   (fifo_full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: slot contents plus a countdown of cycles until arbitration resumes.
    bit           m_pend[N];
    logic [W-1:0] m_buf[N];
    bit           m_err_pend;
    logic [W-1:0] m_err_buf;
    bit           m_ovr;
    int           m_rr;
    int           m_gap;
    bit           m_wr_en;
    logic [W-1:0] m_wr_data;

    int           cyc = 0;
    logic [W-1:0] wq[$];
    int           wc[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_buf[i]  = '0;
        end
        m_err_pend = 1'b0;
        m_err_buf  = '0;
        m_ovr      = 1'b0;
        m_rr       = 0;
        m_gap      = 0;
        m_wr_en    = 1'b0;
        m_wr_data  = '0;
    endtask

    task automatic model_edge();
        bit g_err;
        int g_k;
        g_err = 1'b0;
        g_k   = -1;
        if (!rst_n) return;
        if (m_gap == 0 && !fifo_full) begin
            if (m_err_pend) g_err = 1'b1;
            else
                for (int j = 0; j < N; j++)
                    if (g_k < 0 && m_pend[(m_rr + j) % N]) g_k = (m_rr + j) % N;
        end
        m_wr_en = g_err || (g_k >= 0);
        if (g_err)         m_wr_data = m_err_buf;
        else if (g_k >= 0) m_wr_data = m_buf[g_k];
        if (err_valid) begin
            if (m_err_pend && !g_err) m_ovr = 1'b1;
            m_err_pend = 1'b1;
            m_err_buf  = err_code;
        end else if (g_err) begin
            m_err_pend = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (src_valid[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_buf[i]  = src_data[i*W +: W];
            end
        if (g_k >= 0) begin
            m_pend[g_k] = 1'b0;
            m_rr        = (g_k + 1) % N;
        end
        if (m_wr_en)        m_gap = H + 2;
        else if (m_gap > 0) m_gap--;
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        bit any;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        any = m_err_pend;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = ~m_pend[i];
            any |= m_pend[i];
        end
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("wr_data", 32'(wr_data), 32'(m_wr_data));
        chk("src_ready", 32'(src_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(any || m_gap != 0));
        chk("err_overrun", 32'(err_overrun), 32'(m_ovr));
        if (wr_en) begin
            wq.push_back(wr_data);
            wc.push_back(cyc);
        end
        src_valid = '0;
        err_valid = 1'b0;
    endtask

    task automatic load(input int i, input logic [W-1:0] d);
        src_valid[i]         = 1'b1;
        src_data[i*W +: W]   = d;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'h00);
        chk({tag, "_src_ready"}, 32'(src_ready), 32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
    endtask

    int base;

    initial begin
        model_reset();
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin from rr_ptr=0, then reload 0 and 3.
        load(0, 8'h10); load(1, 8'h11); load(2, 8'h12); load(3, 8'h13);
        steps(24);
        chk("rr_count", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(wq[i]), 32'h10 + 32'(i));
        for (int i = 1; i < 4; i++) chk("rr_gap", 32'(wc[i] - wc[i-1]), 32'(H + 3));
        load(0, 8'h20); load(3, 8'h23);
        steps(14);
        chk("rr2_count", 32'(wq.size()), 32'd6);
        chk("rr2_first", 32'(wq[4]), 32'h20);
        chk("rr2_second", 32'(wq[5]), 32'h23);

        // Single request on source 1.
        load(1, 8'hA5);
        step();
        chk("single_rdy_low", 32'(src_ready[1]), 32'd0);
        step();
        chk("single_wr_en", 32'(wr_en), 32'd1);
        chk("single_wr_data", 32'(wr_data), 32'hA5);
        chk("single_rdy_back", 32'(src_ready[1]), 32'd1);
        step();
        chk("single_pulse", 32'(wr_en), 32'd0);
        steps(6);

        // Error jumps ahead of sources 2 and 3.
        base = wq.size();
        load(0, 8'h30);
        step();
        load(2, 8'h32); load(3, 8'h33);
        step();
        step();
        err_valid = 1'b1; err_code = 8'hEE;
        steps(18);
        chk("errpri_count", 32'(wq.size() - base), 32'd4);
        chk("errpri_0", 32'(wq[base+1]), 32'hEE);
        chk("errpri_1", 32'(wq[base+2]), 32'h32);
        chk("errpri_2", 32'(wq[base+3]), 32'h33);
        chk("errpri_ovr", 32'(err_overrun), 32'd0);

        // Backpressure: nothing leaves while full.
        base = wq.size();
        fifo_full = 1'b1;
        load(0, 8'h40);
        steps(10);
        chk("full_nowrite", 32'(wq.size() - base), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        fifo_full = 1'b0;
        step();
        chk("full_release_wr", 32'(wr_en), 32'd1);
        chk("full_release_data", 32'(wr_data), 32'h40);
        steps(6);

        // Overrun: second error overwrites the first while blocked.
        base = wq.size();
        fifo_full = 1'b1;
        err_valid = 1'b1; err_code = 8'hE1;
        step();
        err_valid = 1'b1; err_code = 8'hE2;
        step();
        chk("ovr_set", 32'(err_overrun), 32'd1);
        steps(3);
        fifo_full = 1'b0;
        steps(8);
        chk("ovr_count", 32'(wq.size() - base), 32'd1);
        chk("ovr_data", 32'(wq[base]), 32'hE2);

        // Asynchronous reset mid-HOLD with sources 0 and 2 still pending.
        fifo_full = 1'b1;
        load(0, 8'h50); load(2, 8'h52);
        err_valid = 1'b1; err_code = 8'h77;
        step();
        fifo_full = 1'b0;
        step();
        step();
        chk("mid_pend", 32'(src_ready), 32'b1010);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) load(i, W'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                err_valid = 1'b1;
                err_code  = W'($urandom);
            end
            if ($urandom_range(0, 7) == 0) fifo_full = ~fifo_full;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
